// File: rtl/arb_pkg.sv
// Shared definitions for the 4-input round-robin arbiter and its requester agent.
package arb_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  // One-hot grant encodings shared with the arbiter.
  localparam logic [NUM_CH-1:0] GNT_CH0 = 4'b0001;
  localparam logic [NUM_CH-1:0] GNT_CH1 = 4'b0010;
  localparam logic [NUM_CH-1:0] GNT_CH2 = 4'b0100;
  localparam logic [NUM_CH-1:0] GNT_CH3 = 4'b1000;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } chan_state_e;

  function automatic logic gnt_is_onehot(input logic [NUM_CH-1:0] g);
    return (g != '0) && ((g & (g - {{(NUM_CH-1){1'b0}}, 1'b1})) == '0);
  endfunction

  function automatic logic [CH_W-1:0] gnt_index(input logic [NUM_CH-1:0] g);
    logic [CH_W-1:0] idx;
    idx = '0;
    case (g)
      GNT_CH0: idx = 2'd0;
      GNT_CH1: idx = 2'd1;
      GNT_CH2: idx = 2'd2;
      GNT_CH3: idx = 2'd3;
      default: idx = '0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_req_agent_if.sv
// Job, request/grant and status signals between the agent and its environment.
interface rr_req_agent_if
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned WASTE_W = 8
);

  logic              job_valid;
  logic [CH_W-1:0]   job_ch;
  logic [LEN_W-1:0]  job_len;
  logic              job_ready;
  logic [NUM_CH-1:0] REQ;
  logic [NUM_CH-1:0] GNT;
  logic              beat_valid;
  logic [CH_W-1:0]   beat_ch;
  logic [NUM_CH-1:0] done;
  logic [WASTE_W-1:0] waste_cnt;
  logic              gnt_err;

  modport master (
    input  job_valid, job_ch, job_len, GNT,
    output job_ready, REQ, beat_valid, beat_ch, done, waste_cnt, gnt_err
  );

  modport slave (
    output job_valid, job_ch, job_len, GNT,
    input  job_ready, REQ, beat_valid, beat_ch, done, waste_cnt, gnt_err
  );

endinterface

// File: rtl/rr_req_chan.sv
// Single requester channel: IDLE/ACTIVE FSM with a beat counter and done pulse.
module rr_req_chan
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             grant_i,
  output logic             active_o,
  output logic             req_o,
  output logic             done_o
);

  chan_state_e      state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Zero-length jobs complete on accept without ever leaving IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (accept_i) begin
          if (len_i != '0) begin
            state_d = CH_ACTIVE;
            cnt_d   = len_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      CH_ACTIVE: begin
        if (grant_i) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = CH_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_comb begin
    active_o = (state_q == CH_ACTIVE);
    req_o    = (state_q == CH_ACTIVE);
    done_o   = done_q;
  end

endmodule

// File: rtl/rr_req_agent.sv
// Requester agent: drives REQ to the round-robin arbiter, retires beats on GNT,
// and counts grants that land on channels that already drained.
module rr_req_agent
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned WASTE_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_req_agent_if.master bus
);

  logic [NUM_CH-1:0]  active, req, done, accept, grant;
  logic               job_ready;
  logic               gnt_onehot, gnt_multi, live_grant;
  logic [CH_W-1:0]    gnt_idx;

  logic               beat_valid_q, beat_valid_d;
  logic [CH_W-1:0]    beat_ch_q, beat_ch_d;
  logic [WASTE_W-1:0] waste_q, waste_d;
  logic               gnt_err_q, gnt_err_d;

  assign job_ready = !active[bus.job_ch];

  // Multi-hot grants are discarded entirely: no beat and no waste count.
  always_comb begin
    gnt_onehot = gnt_is_onehot(bus.GNT);
    gnt_multi  = (bus.GNT != '0) && !gnt_onehot;
    gnt_idx    = gnt_index(bus.GNT);
    grant      = gnt_onehot ? bus.GNT : '0;
    live_grant = |(grant & active);
    accept     = '0;
    if (bus.job_valid && job_ready) begin
      accept[bus.job_ch] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    rr_req_chan #(.LEN_W(LEN_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept_i (accept[i]),
      .len_i    (bus.job_len),
      .grant_i  (grant[i]),
      .active_o (active[i]),
      .req_o    (req[i]),
      .done_o   (done[i])
    );
  end

  always_comb begin
    beat_valid_d = live_grant;
    beat_ch_d    = live_grant ? gnt_idx : beat_ch_q;
    waste_d      = waste_q;
    if (gnt_onehot && !live_grant && (waste_q != '1)) begin
      waste_d = waste_q + WASTE_W'(1);
    end
    gnt_err_d = gnt_err_q | gnt_multi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_valid_q <= 1'b0;
      beat_ch_q    <= '0;
      waste_q      <= '0;
      gnt_err_q    <= 1'b0;
    end else begin
      beat_valid_q <= beat_valid_d;
      beat_ch_q    <= beat_ch_d;
      waste_q      <= waste_d;
      gnt_err_q    <= gnt_err_d;
    end
  end

  assign bus.job_ready  = job_ready;
  assign bus.REQ        = req;
  assign bus.done       = done;
  assign bus.beat_valid = beat_valid_q;
  assign bus.beat_ch    = beat_ch_q;
  assign bus.waste_cnt  = waste_q;
  assign bus.gnt_err    = gnt_err_q;

endmodule

// File: tb/tb_rr_req_agent.sv
// Bench for rr_req_agent: a round-robin arbiter with 2-cycle lag closes the loop,
// and a per-channel remaining-beat model predicts every output each cycle.
module tb_rr_req_agent;
  import arb_pkg::*;

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned WASTE_W = 8;
  localparam int          WMAX    = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_req_agent_if #(.LEN_W(LEN_W), .WASTE_W(WASTE_W)) bus ();

  rr_req_agent #(.LEN_W(LEN_W), .WASTE_W(WASTE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Arbiter in the loop: REQ registered once, then a registered grant.
  logic       force_en;
  logic [3:0] force_val;
  logic [3:0] arb_req_q, arb_gnt;
  int         arb_last;

  function automatic logic [3:0] rr_pick(input logic [3:0] r, input int last);
    for (int off = 1; off <= 4; off++) begin
      if (r[(last + off) % 4]) return 4'b0001 << ((last + off) % 4);
    end
    return 4'b0000;
  endfunction

  function automatic int first_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_req_q <= 4'b0;
      arb_gnt   <= 4'b0;
      arb_last  <= 3;
    end else begin
      arb_req_q <= bus.REQ;
      arb_gnt   <= rr_pick(arb_req_q, arb_last);
      if (rr_pick(arb_req_q, arb_last) != 4'b0) arb_last <= first_idx(rr_pick(arb_req_q, arb_last));
    end
  end

  assign bus.GNT = force_en ? force_val : arb_gnt;

  // Behavioural model: beats left per channel plus expected registered outputs.
  int         rem [4];
  bit         exp_beat;
  int         exp_ch;
  logic [3:0] exp_done;
  int         exp_waste;
  bit         exp_err;

  int unsigned n_chk, n_pass;
  int beats [4];
  int dones [4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rem[i] = 0;
    exp_beat = 0; exp_ch = 0; exp_done = 4'b0; exp_waste = 0; exp_err = 0;
  endtask

  task automatic model_step();
    bit ready;
    int k;
    ready    = (rem[bus.job_ch] == 0);
    exp_beat = 0;
    exp_done = 4'b0;
    if ($countones(bus.GNT) > 1) begin
      exp_err = 1;
    end else if ($countones(bus.GNT) == 1) begin
      k = first_idx(bus.GNT);
      if (rem[k] > 0) begin
        rem[k]   = rem[k] - 1;
        exp_beat = 1;
        exp_ch   = k;
        if (rem[k] == 0) exp_done[k] = 1'b1;
      end else if (exp_waste < WMAX) begin
        exp_waste = exp_waste + 1;
      end
    end
    if (bus.job_valid && ready) begin
      if (bus.job_len == 0) exp_done[bus.job_ch] = 1'b1;
      else rem[bus.job_ch] = int'(bus.job_len);
    end
  endtask

  task automatic compare();
    logic [3:0] exp_req;
    for (int i = 0; i < 4; i++) exp_req[i] = (rem[i] > 0);
    chk("req", bus.REQ, exp_req);
    chk("beat_valid", bus.beat_valid, exp_beat);
    if (exp_beat) chk("beat_ch", bus.beat_ch, exp_ch);
    chk("done", bus.done, exp_done);
    chk("waste_cnt", bus.waste_cnt, exp_waste);
    chk("gnt_err", bus.gnt_err, exp_err);
    chk("job_ready", bus.job_ready, rem[bus.job_ch] == 0);
    if (bus.beat_valid) beats[bus.beat_ch] = beats[bus.beat_ch] + 1;
    for (int i = 0; i < 4; i++) if (bus.done[i]) dones[i] = dones[i] + 1;
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    if (rst_n) compare();
    #1;
  endtask

  task automatic offer(input int ch, input int len);
    bus.job_valid = 1'b1;
    bus.job_ch    = 2'(ch);
    bus.job_len   = 4'(len);
    tick();
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (bus.REQ != 4'b0 && n < budget) begin
      tick();
      n++;
    end
    if (bus.REQ != 4'b0) chk({name, "_timeout"}, 0, 1);
    repeat (4) tick();
  endtask

  int sb [4];
  int sd [4];
  task automatic snap();
    for (int i = 0; i < 4; i++) begin
      sb[i] = beats[i];
      sd[i] = dones[i];
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 4; i++) begin beats[i] = 0; dones[i] = 0; end
    force_en = 1'b0; force_val = 4'b0;
    bus.job_valid = 1'b0; bus.job_ch = 2'd0; bus.job_len = 4'd0;
    model_reset();
    repeat (2) tick();
    chk("rst_req", bus.REQ, 0);
    chk("rst_beat_valid", bus.beat_valid, 0);
    chk("rst_beat_ch", bus.beat_ch, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_waste", bus.waste_cnt, 0);
    chk("rst_gnt_err", bus.gnt_err, 0);
    rst_n = 1'b1;

    // Single job, uncontended: two trailing grants are wasted.
    snap();
    offer(0, 3);
    chk("t1_req_up", bus.REQ, 4'b0001);
    wait_idle(30, "t1");
    chk("t1_beats", beats[0] - sb[0], 3);
    chk("t1_done", dones[0] - sd[0], 1);
    chk("t1_waste", bus.waste_cnt, 2);
    chk("t1_req_down", bus.REQ, 0);

    // Contention across all four channels.
    snap();
    for (int c = 0; c < 4; c++) offer(c, 2);
    wait_idle(80, "t2");
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t2_beats_ch%0d", c), beats[c] - sb[c], 2);
      chk($sformatf("t2_done_ch%0d", c), dones[c] - sd[c], 1);
    end
    chk("t2_gnt_err", bus.gnt_err, 0);

    // Zero-length job.
    bus.job_valid = 1'b1; bus.job_ch = 2'd2; bus.job_len = 4'd0;
    #1 chk("t3_ready", bus.job_ready, 1);
    tick();
    bus.job_valid = 1'b0;
    chk("t3_done", bus.done, 4'b0100);
    chk("t3_req", bus.REQ, 0);
    chk("t3_beat", bus.beat_valid, 0);
    repeat (3) tick();

    // Busy channel ignores a second offer; another channel proceeds.
    snap();
    offer(1, 5);
    tick();
    bus.job_valid = 1'b1; bus.job_ch = 2'd1; bus.job_len = 4'd2;
    #1 chk("t4_busy_ready", bus.job_ready, 0);
    tick();
    offer(3, 1);
    wait_idle(40, "t4");
    chk("t4_beats_ch1", beats[1] - sb[1], 5);
    chk("t4_done_ch1", dones[1] - sd[1], 1);
    chk("t4_beats_ch3", beats[3] - sb[3], 1);

    // Multi-hot grant while ch0 is active: sticky error, no beat.
    snap();
    offer(0, 6);
    repeat (3) tick();
    force_en = 1'b1; force_val = 4'b0011;
    tick();
    force_en = 1'b0;
    chk("t5_err_set", bus.gnt_err, 1);
    chk("t5_no_beat", bus.beat_valid, 0);
    wait_idle(40, "t5");
    chk("t5_err_sticky", bus.gnt_err, 1);
    chk("t5_beats_ch0", beats[0] - sb[0], 6);

    // Waste counter saturation.
    force_en = 1'b1; force_val = 4'b0001;
    repeat (300) tick();
    force_en = 1'b0;
    tick();
    chk("t6_waste_sat", bus.waste_cnt, 255);

    // Reset in the middle of a job.
    snap();
    offer(2, 10);
    for (int n = 0; n < 40 && (beats[2] - sb[2]) < 4; n++) tick();
    chk("t7_four_beats", beats[2] - sb[2], 4);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t7_rst_req", bus.REQ, 0);
    chk("t7_rst_beat", bus.beat_valid, 0);
    chk("t7_rst_done", bus.done, 0);
    chk("t7_rst_waste", bus.waste_cnt, 0);
    chk("t7_rst_err", bus.gnt_err, 0);
    chk("t7_no_done", dones[2] - sd[2], 0);
    repeat (2) tick();
    rst_n = 1'b1;
    snap();
    offer(2, 1);
    wait_idle(20, "t7");
    chk("t7_beats", beats[2] - sb[2], 1);
    chk("t7_done", dones[2] - sd[2], 1);

    // Randomized traffic with occasional forced grants.
    for (int n = 0; n < 1500; n++) begin
      bus.job_valid = 1'($urandom_range(0, 1));
      bus.job_ch    = 2'($urandom_range(0, 3));
      bus.job_len   = 4'($urandom_range(0, 15));
      force_en      = ($urandom_range(0, 9) == 0);
      force_val     = 4'($urandom_range(0, 15));
      tick();
    end
    bus.job_valid = 1'b0;
    force_en = 1'b0;
    wait_idle(200, "rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
